// File: rtl/magic_nmi_pkg.sv
// Shared types and constants for the Magic (NMI) button logic.
package magic_nmi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    MAPPED,
    RETN_ED
  } magic_state_t;

  localparam logic [15:0] MAGIC_NMI_VECTOR = 16'h0066;
  localparam logic [7:0]  OPCODE_ED_PREFIX = 8'hED;

  // Second byte of RETN and its undocumented aliases: ED 45/4D/55/5D/65/6D/75/7D.
  function automatic logic is_retn_opcode(input logic [7:0] op);
    return (op[7:6] == 2'b01) && (op[2:0] == 3'b101);
  endfunction

endpackage

// File: rtl/m1_fetch_tracker.sv
// Tracks Z80 M1 opcode fetches: first cycle of a fetch, captured opcode,
// and a one-cycle strobe when the captured opcode is final (refresh phase).
module m1_fetch_tracker (
  input  logic       clkcpu,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       m1,
  input  logic       mreq,
  input  logic       rd,
  input  logic       rfsh,
  input  logic [7:0] d,
  output logic       fetch_start,
  output logic       fetch_done,
  output logic [7:0] opcode
);

  logic fetch;
  logic fetch_q;

  assign fetch       = m1 & mreq & rd & ~rfsh;
  assign fetch_start = fetch & ~fetch_q;
  assign fetch_done  = fetch_q & rfsh;

  // The opcode keeps reloading while the fetch lasts so the last sampled byte wins.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      fetch_q <= 1'b0;
      opcode  <= 8'h00;
    end else if (clear) begin
      fetch_q <= 1'b0;
      opcode  <= 8'h00;
    end else begin
      fetch_q <= fetch;
      if (fetch) begin
        opcode <= d;
      end
    end
  end

endmodule

// File: rtl/magic_nmi.sv
// Magic button handler: button -> NMI request, magic ROM mapped from the
// 0x0066 fetch until a RETN-class instruction has been fetched.
module magic_nmi
  import magic_nmi_pkg::*;
#(
  parameter int NMI_TIMEOUT = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic        rst_n,
  input  logic        clkcpu,
  input  logic        n_rstcpu,
  input  logic        magic_button,
  input  logic        magic_enable,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        m1,
  input  logic        mreq,
  input  logic        rd,
  input  logic        rfsh,
  output logic        n_nmi,
  output logic        magic_map,
  output logic        magic_active
);

  localparam logic [7:0] TIMEOUT_COUNT = 8'(NMI_TIMEOUT);

  logic                   clear;
  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_qq;
  logic [SYNC_STAGES:0]   sync_valid;
  logic                   press;

  logic                   fetch_start;
  logic                   fetch_done;
  logic [7:0]             opcode;

  magic_state_t           state;
  magic_state_t           next_state;
  logic [7:0]             count;
  logic [7:0]             count_next;
  logic                   n_nmi_next;
  logic                   map_next;

  assign clear = ~n_rstcpu;

  m1_fetch_tracker u_fetch (
    .clkcpu      (clkcpu),
    .rst_n       (rst_n),
    .clear       (clear),
    .m1          (m1),
    .mreq        (mreq),
    .rd          (rd),
    .rfsh        (rfsh),
    .d           (d),
    .fetch_start (fetch_start),
    .fetch_done  (fetch_done),
    .opcode      (opcode)
  );

  // sync_valid marks stages holding real post-reset samples, so a button
  // held through reset is not mistaken for a fresh press.
  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      sync       <= '0;
      sync_qq    <= 1'b0;
      sync_valid <= '0;
    end else if (clear) begin
      sync       <= '0;
      sync_qq    <= 1'b0;
      sync_valid <= '0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], magic_button};
      sync_qq    <= sync[SYNC_STAGES-1];
      sync_valid <= {sync_valid[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign press = sync[SYNC_STAGES-1] & ~sync_qq & sync_valid[SYNC_STAGES] & magic_enable;

  always_ff @(posedge clkcpu or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 8'h00;
      n_nmi        <= 1'b1;
      magic_map    <= 1'b0;
      magic_active <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      count        <= 8'h00;
      n_nmi        <= 1'b1;
      magic_map    <= 1'b0;
      magic_active <= 1'b0;
    end else begin
      state        <= next_state;
      count        <= (next_state == PENDING) ? count_next : 8'h00;
      n_nmi        <= n_nmi_next;
      magic_map    <= map_next;
      magic_active <= map_next;
    end
  end

  // Outputs are decoded from next_state so they change on the same edge as the state.
  always_comb begin
    next_state = state;
    count_next = 8'h00;
    case (state)
      IDLE: begin
        if (press) begin
          next_state = PENDING;
        end
      end
      PENDING: begin
        count_next = count + 8'd1;
        if (fetch_start && (a == MAGIC_NMI_VECTOR)) begin
          next_state = MAPPED;
        end else if (count_next == TIMEOUT_COUNT) begin
          next_state = IDLE;
        end
      end
      MAPPED: begin
        if (fetch_done && (opcode == OPCODE_ED_PREFIX)) begin
          next_state = RETN_ED;
        end
      end
      RETN_ED: begin
        if (fetch_done) begin
          if (is_retn_opcode(opcode)) begin
            next_state = IDLE;
          end else if (opcode == OPCODE_ED_PREFIX) begin
            next_state = RETN_ED;
          end else begin
            next_state = MAPPED;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    n_nmi_next = (next_state != PENDING);
    map_next   = (next_state == MAPPED) || (next_state == RETN_ED);
  end

endmodule

// File: tb/tb_magic_nmi.sv
// Directed bench for magic_nmi: button entry, RETN exit variants, timeout and masking.
module tb_magic_nmi;

  logic        clkcpu;
  logic        rst_n;
  logic        n_rstcpu;
  logic        magic_button;
  logic        magic_enable;
  logic [15:0] a;
  logic [7:0]  d;
  logic        m1;
  logic        mreq;
  logic        rd;
  logic        rfsh;
  logic        n_nmi;
  logic        magic_map;
  logic        magic_active;

  int checks   = 0;
  int failures = 0;

  logic map_first;
  logic nmi_first;
  logic map_pre;
  int   low_cycles;

  magic_nmi #(
    .NMI_TIMEOUT (255),
    .SYNC_STAGES (2)
  ) dut (
    .rst_n        (rst_n),
    .clkcpu       (clkcpu),
    .n_rstcpu     (n_rstcpu),
    .magic_button (magic_button),
    .magic_enable (magic_enable),
    .a            (a),
    .d            (d),
    .m1           (m1),
    .mreq         (mreq),
    .rd           (rd),
    .rfsh         (rfsh),
    .n_nmi        (n_nmi),
    .magic_map    (magic_map),
    .magic_active (magic_active)
  );

  initial begin
    clkcpu = 1'b0;
    forever #5 clkcpu = ~clkcpu;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data,
                               input logic m1_i, input logic mreq_i, input logic rd_i, input logic rfsh_i);
    a    = addr;
    d    = data;
    m1   = m1_i;
    mreq = mreq_i;
    rd   = rd_i;
    rfsh = rfsh_i;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clkcpu);
      #1;
    end
  endtask

  // Two fetch cycles then one refresh cycle; returns just after the fetch_done edge.
  task automatic m1Fetch(input logic [15:0] addr, input logic [7:0] op,
                         output logic mf, output logic nf, output logic mp);
    applyStimulus(addr, op, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(1);
    mf = magic_map;
    nf = n_nmi;
    tick(1);
    mp = magic_map;
    applyStimulus(16'h0000, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(1);
    applyStimulus(16'h0000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enterMapped(input string tag);
    logic mf, nf, mp;
    magic_button = 1'b1;
    tick(3);
    magic_button = 1'b0;
    m1Fetch(16'h0066, 8'hF5, mf, nf, mp);
    checkOutput(tag, {29'd0, magic_active, magic_map, n_nmi}, 32'd7);
  endtask

  initial begin
    rst_n        = 1'b0;
    n_rstcpu     = 1'b1;
    magic_button = 1'b1;
    magic_enable = 1'b1;
    applyStimulus(16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset with button held.
    tick(3);
    checkOutput("reset_n_nmi", n_nmi, 1);
    checkOutput("reset_map", magic_map, 0);
    checkOutput("reset_active", magic_active, 0);
    rst_n = 1'b1;
    tick(6);
    checkOutput("held_button_no_nmi", n_nmi, 1);
    magic_button = 1'b0;
    tick(4);

    // Normal entry: 2 sync edges + 1 FSM edge.
    magic_button = 1'b1;
    tick(1);
    checkOutput("entry_edge1", n_nmi, 1);
    tick(1);
    checkOutput("entry_edge2", n_nmi, 1);
    tick(1);
    checkOutput("entry_edge3", n_nmi, 0);
    tick(17);
    magic_button = 1'b0;
    checkOutput("pending_hold", n_nmi, 0);

    m1Fetch(16'h1234, 8'h00, map_first, nmi_first, map_pre);
    checkOutput("other_fetch_no_map", {30'd0, map_first, nmi_first}, 32'd0);
    applyStimulus(16'h0066, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(2);
    checkOutput("non_m1_read_no_map", {30'd0, magic_map, n_nmi}, 32'd0);
    applyStimulus(16'h0000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1);

    m1Fetch(16'h0066, 8'hF3, map_first, nmi_first, map_pre);
    checkOutput("vec_map_first", map_first, 1);
    checkOutput("vec_nmi_first", nmi_first, 1);
    checkOutput("vec_active", magic_active, 1);

    // RETN exit ED 45.
    m1Fetch(16'h0100, 8'hED, map_first, nmi_first, map_pre);
    checkOutput("ed45_after_ed", magic_map, 1);
    m1Fetch(16'h0101, 8'h45, map_first, nmi_first, map_pre);
    checkOutput("ed45_map_during", map_pre, 1);
    checkOutput("ed45_unmapped", {30'd0, magic_map, magic_active}, 32'd0);
    tick(2);

    // ED 7D also exits.
    enterMapped("enter_7d");
    m1Fetch(16'h0100, 8'hED, map_first, nmi_first, map_pre);
    m1Fetch(16'h0101, 8'h7D, map_first, nmi_first, map_pre);
    checkOutput("ed7d_map_during", map_pre, 1);
    checkOutput("ed7d_unmapped", magic_map, 0);
    tick(2);

    // ED 44 (NEG) stays mapped, then ED ED 45 exits only after the 45.
    enterMapped("enter_44");
    m1Fetch(16'h0100, 8'hED, map_first, nmi_first, map_pre);
    m1Fetch(16'h0101, 8'h44, map_first, nmi_first, map_pre);
    checkOutput("ed44_stays", {30'd0, magic_map, magic_active}, 32'd3);
    m1Fetch(16'h0102, 8'hED, map_first, nmi_first, map_pre);
    m1Fetch(16'h0103, 8'hED, map_first, nmi_first, map_pre);
    checkOutput("eded_stays", magic_map, 1);
    m1Fetch(16'h0104, 8'h45, map_first, nmi_first, map_pre);
    checkOutput("eded45_unmapped", magic_map, 0);
    tick(2);

    // ED 00 returns to MAPPED; refresh-only cycles and presses change nothing.
    enterMapped("enter_ed00");
    m1Fetch(16'h0100, 8'hED, map_first, nmi_first, map_pre);
    m1Fetch(16'h0101, 8'h00, map_first, nmi_first, map_pre);
    checkOutput("ed00_mapped", {30'd0, magic_map, magic_active}, 32'd3);
    applyStimulus(16'h0045, 8'h45, 1'b0, 1'b1, 1'b0, 1'b1);
    tick(4);
    applyStimulus(16'h0000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rfsh_only_mapped", magic_map, 1);
    magic_button = 1'b1;
    tick(6);
    magic_button = 1'b0;
    checkOutput("press_in_mapped", n_nmi, 1);
    n_rstcpu = 1'b0;
    tick(1);
    n_rstcpu = 1'b1;
    checkOutput("rstcpu_unmap", {29'd0, magic_active, magic_map, n_nmi}, 32'd1);
    tick(4);

    // Timeout after exactly NMI_TIMEOUT low cycles.
    magic_button = 1'b1;
    tick(3);
    magic_button = 1'b0;
    checkOutput("timeout_assert", n_nmi, 0);
    low_cycles = 1;
    for (int i = 0; i < 400; i++) begin
      tick(1);
      if (n_nmi) break;
      low_cycles++;
    end
    checkOutput("timeout_len", low_cycles, 255);
    checkOutput("timeout_idle", {30'd0, magic_map, magic_active}, 32'd0);
    tick(2);
    magic_button = 1'b1;
    tick(3);
    magic_button = 1'b0;
    checkOutput("repress_assert", n_nmi, 0);

    // Enable dropping while pending does not cancel; sequence still completes.
    magic_enable = 1'b0;
    tick(10);
    checkOutput("enable_drop_pending", n_nmi, 0);
    m1Fetch(16'h0066, 8'h00, map_first, nmi_first, map_pre);
    checkOutput("enable_drop_map", {30'd0, magic_map, n_nmi}, 32'd3);
    m1Fetch(16'h0100, 8'hED, map_first, nmi_first, map_pre);
    m1Fetch(16'h0101, 8'h4D, map_first, nmi_first, map_pre);
    checkOutput("enable_drop_exit", magic_map, 0);
    tick(2);

    // Press ignored while disabled.
    magic_button = 1'b1;
    tick(6);
    magic_button = 1'b0;
    checkOutput("disabled_press", n_nmi, 1);
    magic_enable = 1'b1;
    tick(4);

    // Press on the same edge as a CPU reset: reset wins, held button then ignored.
    magic_button = 1'b1;
    tick(2);
    n_rstcpu = 1'b0;
    tick(1);
    n_rstcpu = 1'b1;
    checkOutput("press_vs_reset", n_nmi, 1);
    tick(5);
    checkOutput("held_after_rstcpu", n_nmi, 1);
    magic_button = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
